// File: rtl/pc_fetch_ctrl_abc_pkg.sv
// Shared types and constants for the PC/fetch sequencer: FSM states, widths, branch-target table.
package pc_fetch_ctrl_abc_pkg;

  localparam int DEF_PC_W       = 10;
  localparam int DEF_LUT_IDX_W  = 4;
  localparam int DEF_START_ADDR = 0;
  localparam int LUT_DEPTH      = 2 ** DEF_LUT_IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_st_e;

  typedef logic [DEF_PC_W-1:0] pc_t;

  // Entry i holds i*16; regenerated by the assembler flow when the program layout changes.
  localparam pc_t kBR_LUT [LUT_DEPTH] = '{
    10'd0,   10'd16,  10'd32,  10'd48,  10'd64,  10'd80,  10'd96,  10'd112,
    10'd128, 10'd144, 10'd160, 10'd176, 10'd192, 10'd208, 10'd224, 10'd240
  };

endpackage

// File: rtl/pc_fetch_ctrl_abc_branch_lut.sv
// Combinational branch-index to target-address lookup over the constant table.
// Zero latency; no flow control (pure combinational).
module branch_lut_abc
  import pc_fetch_ctrl_abc_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int LUT_IDX_W = DEF_LUT_IDX_W
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      target
);

  assign target = PC_W'(kBR_LUT[idx]);

endmodule

// File: rtl/pc_fetch_ctrl_abc.sv
// PC/fetch sequencer: IDLE/RUN/HALTED FSM, PC register, ALU carry flop, wrap flag and branch counter.
// New PC visible one edge after the deciding inputs; STALL freezes every register while running.
module pc_fetch_ctrl_abc
  import pc_fetch_ctrl_abc_pkg::*;
#(
  parameter int              PC_W       = DEF_PC_W,
  parameter int              LUT_IDX_W  = DEF_LUT_IDX_W,
  parameter logic [PC_W-1:0] START_ADDR = PC_W'(DEF_START_ADDR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 br_en,
  input  logic                 br_flag,
  input  logic [LUT_IDX_W-1:0] br_idx,
  input  logic                 sc_we,
  input  logic                 sc_out_alu,
  output logic                 sc_in_alu,
  output logic [PC_W-1:0]      pc,
  output logic                 fetch_valid,
  output logic                 done,
  output logic                 pc_wrap,
  output logic [7:0]           br_cnt
);

  fetch_st_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            sc_q, sc_d;
  logic            wrap_q, wrap_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] br_target;

  branch_lut_abc #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_lut (
    .idx    (br_idx),
    .target (br_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      sc_q    <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sc_d    = sc_q;
    wrap_d  = wrap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          sc_d    = 1'b0;
          wrap_d  = 1'b0;
          cnt_d   = 8'd0;
        end
      end
      RUN: begin
        if (!stall) begin
          // Carry capture is independent of which PC source wins, including the halt cycle.
          if (sc_we) sc_d = sc_out_alu;
          if (halt) begin
            state_d = HALTED;
          end else if (br_en && br_flag) begin
            pc_d  = br_target;
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          end else begin
            pc_d = pc_q + PC_W'(1);
            if (&pc_q) wrap_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc          = pc_q;
  assign sc_in_alu   = sc_q;
  assign pc_wrap     = wrap_q;
  assign br_cnt      = cnt_q;
  assign fetch_valid = (state_q == RUN);
  assign done        = (state_q == HALTED);

endmodule

// File: tb/tb_pc_fetch_ctrl_abc.sv
// Self-checking bench for pc_fetch_ctrl_abc: per-scenario tasks with a queue of expected PCs.
module tb_pc_fetch_ctrl_abc;

  logic       clk;
  logic       rst_n;
  logic       start, stall, halt, br_en, br_flag, sc_we, sc_out_alu;
  logic [3:0] br_idx;
  logic       sc_in_alu, fetch_valid, done, pc_wrap;
  logic [9:0] pc;
  logic [7:0] br_cnt;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_pc_q [$];
  logic [9:0] exp_pc;

  pc_fetch_ctrl_abc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .halt        (halt),
    .br_en       (br_en),
    .br_flag     (br_flag),
    .br_idx      (br_idx),
    .sc_we       (sc_we),
    .sc_out_alu  (sc_out_alu),
    .sc_in_alu   (sc_in_alu),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .done        (done),
    .pc_wrap     (pc_wrap),
    .br_cnt      (br_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; halt = 0; br_en = 0; br_flag = 0;
    br_idx = 0; sc_we = 0; sc_out_alu = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    checks++; if (pc !== 10'd0 || fetch_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_state: pc=%0d fv=%b done=%b, want 0/0/0", pc, fetch_valid, done); end
    checks++; if (sc_in_alu !== 1'b0 || pc_wrap !== 1'b0 || br_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_flags: sc=%b wrap=%b cnt=%0d, want 0/0/0", sc_in_alu, pc_wrap, br_cnt); end
    tick();
    rst_n = 1;
    tick();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 37; i++) tick();
    checks++; if (pc !== 10'd37 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL run_to_37: pc=%0d fv=%b, want 37/1", pc, fetch_valid); end
    #2 rst_n = 0;
    #1;
    checks++; if (pc !== 10'd0 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: pc=%0d fv=%b, want 0/0", pc, fetch_valid); end
    tick();
    rst_n = 1;
    tick();
    start = 1;
    exp_pc_q.push_back(10'd0);
    tick();
    start = 0;
    exp_pc = exp_pc_q.pop_front();
    checks++; if (pc !== exp_pc) begin
      errors++; $display("FAIL start_seq: pc=%0d want %0d", pc, exp_pc); end
    for (int i = 1; i <= 3; i++) begin
      exp_pc_q.push_back(10'(i));
      tick();
      exp_pc = exp_pc_q.pop_front();
      checks++; if (pc !== exp_pc) begin
        errors++; $display("FAIL start_seq: pc=%0d want %0d", pc, exp_pc); end
    end
  endtask

  task automatic test_branch();
    tick(); tick();
    checks++; if (pc !== 10'd5) begin
      errors++; $display("FAIL br_pre: pc=%0d want 5", pc); end
    // Not-taken branch, then flag without enable, then taken branches.
    br_en = 1; br_flag = 0; br_idx = 3; exp_pc_q.push_back(10'd6);
    tick();
    br_en = 0; br_flag = 1;           exp_pc_q.push_back(10'd7);
    exp_pc = exp_pc_q.pop_front();
    checks++; if (pc !== exp_pc || br_cnt !== 8'd0) begin
      errors++; $display("FAIL br_not_taken: pc=%0d cnt=%0d want %0d/0", pc, br_cnt, exp_pc); end
    tick();
    exp_pc = exp_pc_q.pop_front();
    checks++; if (pc !== exp_pc || br_cnt !== 8'd0) begin
      errors++; $display("FAIL br_flag_only: pc=%0d cnt=%0d want %0d/0", pc, br_cnt, exp_pc); end
    br_en = 1; br_flag = 1; br_idx = 3; exp_pc_q.push_back(10'd48);
    tick();
    exp_pc = exp_pc_q.pop_front();
    checks++; if (pc !== exp_pc || br_cnt !== 8'd1) begin
      errors++; $display("FAIL br_taken: pc=%0d cnt=%0d want %0d/1", pc, br_cnt, exp_pc); end
    br_idx = 15; exp_pc_q.push_back(10'd240);
    tick();
    br_en = 0; br_flag = 0;
    exp_pc = exp_pc_q.pop_front();
    checks++; if (pc !== exp_pc || br_cnt !== 8'd2) begin
      errors++; $display("FAIL br_idx15: pc=%0d cnt=%0d want %0d/2", pc, br_cnt, exp_pc); end
  endtask

  task automatic test_stall();
    stall = 1; halt = 1; br_en = 1; br_flag = 1; br_idx = 1; sc_we = 1; sc_out_alu = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 10'd240 || fetch_valid !== 1'b1 || done !== 1'b0 ||
                    sc_in_alu !== 1'b0 || br_cnt !== 8'd2) begin
        errors++; $display("FAIL stall_freeze: pc=%0d fv=%b done=%b sc=%b cnt=%0d, want 240/1/0/0/2",
                           pc, fetch_valid, done, sc_in_alu, br_cnt); end
    end
    stall = 0; halt = 0; sc_we = 0;
    exp_pc_q.push_back(10'd16);
    tick();
    br_en = 0; br_flag = 0;
    exp_pc = exp_pc_q.pop_front();
    checks++; if (pc !== exp_pc || br_cnt !== 8'd3) begin
      errors++; $display("FAIL stall_release_br: pc=%0d cnt=%0d want %0d/3", pc, br_cnt, exp_pc); end
  endtask

  task automatic test_halt_restart();
    br_en = 1; br_flag = 1; br_idx = 0;
    tick();
    br_en = 0; br_flag = 0;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (pc !== 10'd9) begin
      errors++; $display("FAIL halt_pre: pc=%0d want 9", pc); end
    halt = 1; sc_we = 1; sc_out_alu = 1;
    tick();
    halt = 0; sc_out_alu = 0;
    checks++; if (pc !== 10'd9 || done !== 1'b1 || fetch_valid !== 1'b0 || sc_in_alu !== 1'b1) begin
      errors++; $display("FAIL halt: pc=%0d done=%b fv=%b sc=%b, want 9/1/0/1", pc, done, fetch_valid, sc_in_alu); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (pc !== 10'd9 || done !== 1'b1 || sc_in_alu !== 1'b1 || br_cnt !== 8'd4) begin
      errors++; $display("FAIL halted_hold: pc=%0d done=%b sc=%b cnt=%0d, want 9/1/1/4", pc, done, sc_in_alu, br_cnt); end
    sc_we = 0; start = 1;
    tick();
    start = 0;
    checks++; if (pc !== 10'd0 || done !== 1'b0 || br_cnt !== 8'd0 || sc_in_alu !== 1'b0 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL restart: pc=%0d done=%b cnt=%0d sc=%b fv=%b, want 0/0/0/0/1",
                         pc, done, br_cnt, sc_in_alu, fetch_valid); end
  endtask

  task automatic test_wrap();
    br_en = 1; br_flag = 1; br_idx = 15;
    tick();
    br_en = 0; br_flag = 0;
    for (int i = 0; i < 782; i++) tick();
    checks++; if (pc !== 10'd1022 || pc_wrap !== 1'b0) begin
      errors++; $display("FAIL wrap_pre: pc=%0d wrap=%b, want 1022/0", pc, pc_wrap); end
    exp_pc_q.push_back(10'd1023); exp_pc_q.push_back(10'd0); exp_pc_q.push_back(10'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = exp_pc_q.pop_front();
      checks++; if (pc !== exp_pc || pc_wrap !== (i != 0)) begin
        errors++; $display("FAIL wrap_seq: pc=%0d wrap=%b want %0d/%b", pc, pc_wrap, exp_pc, (i != 0)); end
    end
    halt = 1;
    tick();
    halt = 0;
    checks++; if (pc_wrap !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL wrap_sticky: wrap=%b done=%b, want 1/1", pc_wrap, done); end
    start = 1;
    tick();
    start = 0;
    checks++; if (pc_wrap !== 1'b0 || pc !== 10'd0) begin
      errors++; $display("FAIL wrap_clear: wrap=%b pc=%0d, want 0/0", pc_wrap, pc); end
  endtask

  task automatic test_carry_sat();
    sc_we = 1; sc_out_alu = 1;
    tick();
    checks++; if (sc_in_alu !== 1'b1) begin
      errors++; $display("FAIL carry_load: sc=%b want 1", sc_in_alu); end
    sc_we = 0;
    for (int i = 0; i < 3; i++) begin
      sc_out_alu = i[0];
      tick();
      checks++; if (sc_in_alu !== 1'b1) begin
        errors++; $display("FAIL carry_hold: sc=%b want 1", sc_in_alu); end
    end
    sc_we = 1; sc_out_alu = 0;
    tick();
    sc_we = 0;
    checks++; if (sc_in_alu !== 1'b0) begin
      errors++; $display("FAIL carry_clear: sc=%b want 0", sc_in_alu); end
    br_en = 1; br_flag = 1; br_idx = 2;
    for (int i = 0; i < 255; i++) tick();
    checks++; if (br_cnt !== 8'hFF || pc !== 10'd32) begin
      errors++; $display("FAIL cnt_255: cnt=%0d pc=%0d, want 255/32", br_cnt, pc); end
    tick();
    br_en = 0; br_flag = 0;
    checks++; if (br_cnt !== 8'hFF) begin
      errors++; $display("FAIL cnt_sat: cnt=%0d want 255", br_cnt); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_halt_restart();
    test_wrap();
    test_carry_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
